// File: rtl/fpga_cfg_loader_pkg.sv
// Shared state encoding and defaults for the fabric configuration loader.
// The loader and its slot shifter both import this package.
package fpga_cfg_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } cfg_state_e;

  localparam int   DEF_NUM_WORDS = 15;
  localparam int   DEF_WORD_W    = 32;
  localparam int   DEF_ADDR_W    = 4;
  localparam logic PAD_BIT       = 1'b0;

  // Abort is only honoured while a run owns the chain (FETCH through LATCH).
  function automatic logic is_run_state(input cfg_state_e s);
    return (s inside {S_FETCH, S_LOAD, S_SHIFT, S_LATCH});
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Synchronous configuration ROM port. The loader is the master and the
// ROM returns data one cycle after a read strobe.
interface fpga_cfg_loader_if import fpga_cfg_loader_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
);

  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_rdata;

  modport master (
    output rom_rd,
    output rom_addr,
    input  rom_rdata
  );

  modport slave (
    input  rom_rd,
    input  rom_addr,
    output rom_rdata
  );

endinterface

// File: rtl/fpga_cfg_loader_cfg_shifter.sv
// One chain slot: parallel-load {pad, word} register shifted out MSB first,
// with a down-counter flagging the final bit of the slot.
module cfg_shifter import fpga_cfg_loader_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              last,
  output logic              msb
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W:0]  shreg_r;
  logic [CNT_W-1:0] cnt_r;

  // Slot register and bit counter; load takes priority over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      shreg_r <= {PAD_BIT, data};
      cnt_r   <= CNT_W'(WORD_W);
    end else if (shift) begin
      // Zero-fill so the register is empty once the slot is fully out.
      shreg_r <= {shreg_r[WORD_W-1:0], 1'b0};
      if (cnt_r != '0) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  assign last = (cnt_r == '0);
  assign msb  = shreg_r[WORD_W];

endmodule

// File: rtl/fpga_cfg_loader.sv
// Fabric configuration loader: fetches ROM words in descending address order,
// shifts each out as a padded slot on sin/cfg_en, then pulses cfg_latch.
module fpga_cfg_loader import fpga_cfg_loader_pkg::*; #(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  fpga_cfg_loader_if.master   rom,
  output logic                sin,
  output logic                cfg_en,
  output logic                cfg_latch
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  cfg_state_e        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              rom_rd_r;
  logic              busy_r;
  logic              done_r;
  logic              cfg_en_r;
  logic              cfg_latch_r;

  logic              abort_run_s;
  logic              load_s;
  logic              shift_s;
  logic              last_s;
  logic              msb_s;
  logic [WORD_W-1:0] load_data_s;

  assign abort_run_s = abort && is_run_state(state_r);

  // Shifter control; an abort reloads zeros so sin is quiet while cfg_en is low.
  always_comb begin
    load_s      = 1'b0;
    shift_s     = 1'b0;
    load_data_s = rom.rom_rdata;
    if (abort_run_s) begin
      load_s      = 1'b1;
      load_data_s = '0;
    end else if (state_r == S_LOAD) begin
      load_s = 1'b1;
    end else if (state_r == S_SHIFT) begin
      shift_s = 1'b1;
    end else begin
      load_s  = 1'b0;
      shift_s = 1'b0;
    end
  end

  cfg_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .shift (shift_s),
    .data  (load_data_s),
    .last  (last_s),
    .msb   (msb_s)
  );

  // Run sequencer with registered (Moore) outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      rom_addr_r  <= '0;
      rom_rd_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_en_r    <= 1'b0;
      cfg_latch_r <= 1'b0;
    end else if (abort_run_s) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      rom_addr_r  <= '0;
      rom_rd_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_en_r    <= 1'b0;
      cfg_latch_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r    <= S_FETCH;
            idx_r      <= LAST_IDX;
            rom_addr_r <= LAST_IDX;
            rom_rd_r   <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        S_FETCH: begin
          rom_rd_r <= 1'b0;
          state_r  <= S_LOAD;
        end
        S_LOAD: begin
          cfg_en_r <= 1'b1;
          state_r  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (last_s) begin
            cfg_en_r <= 1'b0;
            if (idx_r == '0) begin
              rom_addr_r  <= '0;
              cfg_latch_r <= 1'b1;
              state_r     <= S_LATCH;
            end else begin
              idx_r      <= idx_r - IDX_ONE;
              rom_addr_r <= idx_r - IDX_ONE;
              rom_rd_r   <= 1'b1;
              state_r    <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          cfg_latch_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          idx_r       <= '0;
          rom_addr_r  <= '0;
          rom_rd_r    <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          cfg_en_r    <= 1'b0;
          cfg_latch_r <= 1'b0;
        end
      endcase
    end
  end

  assign rom.rom_rd   = rom_rd_r;
  assign rom.rom_addr = rom_addr_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign cfg_en       = cfg_en_r;
  assign cfg_latch    = cfg_latch_r;
  assign sin          = msb_s;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: default-size instance plus a 1-word/8-bit corner
// instance, each fed by a behavioural ROM and checked against a stream model.
module tb_fpga_cfg_loader;

  localparam int NW      = 15;
  localparam int WW      = 32;
  localparam int AW      = 4;
  localparam int RUN_CYC = NW * (WW + 3) + 2;
  localparam int MAX_CYC = RUN_CYC + 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- default-size instance ----------------
  logic start_a = 1'b0;
  logic abort_a = 1'b0;
  logic busy_a, done_a, sin_a, cfg_en_a, cfg_latch_a;
  logic [WW-1:0] mem_a [16];

  fpga_cfg_loader_if #(.ADDR_W(AW), .WORD_W(WW)) rom_a ();

  fpga_cfg_loader #(.NUM_WORDS(NW), .WORD_W(WW), .ADDR_W(AW)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .abort     (abort_a),
    .busy      (busy_a),
    .done      (done_a),
    .rom       (rom_a),
    .sin       (sin_a),
    .cfg_en    (cfg_en_a),
    .cfg_latch (cfg_latch_a)
  );

  always @(posedge clk) if (rom_a.rom_rd) rom_a.rom_rdata <= mem_a[rom_a.rom_addr];

  // ---------------- corner instance: 1 word of 8 bits ----------------
  logic start_b = 1'b0;
  logic abort_b = 1'b0;
  logic busy_b, done_b, sin_b, cfg_en_b, cfg_latch_b;
  logic [7:0] mem_b = 8'h00;

  fpga_cfg_loader_if #(.ADDR_W(1), .WORD_W(8)) rom_b ();

  fpga_cfg_loader #(.NUM_WORDS(1), .WORD_W(8), .ADDR_W(1)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .busy      (busy_b),
    .done      (done_b),
    .rom       (rom_b),
    .sin       (sin_b),
    .cfg_en    (cfg_en_b),
    .cfg_latch (cfg_latch_b)
  );

  always @(posedge clk) if (rom_b.rom_rd) rom_b.rom_rdata <= mem_b;

  // ---------------- observation state ----------------
  bit            got[$];
  logic [AW-1:0] addrs[$];
  int done_cyc, done_cnt, en_cnt, latch_cnt, rd_long, sin_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode 0: single start pulse; 1: start held until done; 2: extra pulse mid-SHIFT.
  task automatic run_a(input int mode, input int abort_cyc);
    bit rd_prev;
    got.delete();
    addrs.delete();
    done_cyc = -1; done_cnt = 0; en_cnt = 0; latch_cnt = 0; rd_long = 0; sin_bad = 0;
    rd_prev = 1'b0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      @(negedge clk);
      if (cfg_en_a) begin
        en_cnt++;
        got.push_back(sin_a);
      end else if (sin_a !== 1'b0) begin
        sin_bad++;
      end
      if (rom_a.rom_rd) begin
        addrs.push_back(rom_a.rom_addr);
        if (rd_prev) rd_long++;
      end
      rd_prev = rom_a.rom_rd;
      if (cfg_latch_a) latch_cnt++;
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 1) chk("fetch_outs", {busy_a, rom_a.rom_rd, rom_a.rom_addr}, {1'b1, 1'b1, AW'(NW - 1)});
      if (cyc == 3) chk("first_en", cfg_en_a, 1'b1);
      if (cyc == abort_cyc + 1) begin
        chk("abort_en", cfg_en_a, 1'b0);
        chk("abort_busy", busy_a, 1'b0);
        abort_a = 1'b0;
      end
      if (mode == 1) begin
        if (done_a) start_a = 1'b0;
      end else if (mode == 2) begin
        start_a = (cyc == 150);
      end else begin
        start_a = 1'b0;
      end
      if (cyc == abort_cyc) abort_a = 1'b1;
    end
    start_a = 1'b0;
    chk("idle_after", {busy_a, cfg_en_a, rom_a.rom_rd}, 3'b000);
  endtask

  // Reference: slots in descending address order, each a 0 pad then MSB..LSB.
  task automatic verify_a(input bit full, input int abort_cyc);
    bit exp_s[$];
    int n_bits, n_words, bad;
    logic [AW-1:0] ea;
    for (int w = NW - 1; w >= 0; w--) begin
      exp_s.push_back(1'b0);
      for (int b = WW - 1; b >= 0; b--) exp_s.push_back(mem_a[w][b]);
    end
    if (full) begin
      n_bits  = NW * (WW + 1);
      n_words = NW;
    end else begin
      n_bits = 0;
      for (int c = 1; c <= abort_cyc; c++) if ((c - 1) % (WW + 3) >= 2) n_bits++;
      n_words = (abort_cyc - 1) / (WW + 3) + 1;
    end
    chk("stream_len", got.size(), n_bits);
    bad = 0;
    for (int i = 0; i < got.size() && i < n_bits; i++) if (got[i] !== exp_s[i]) bad++;
    chk("stream_bits", bad, 0);
    chk("addr_cnt", addrs.size(), n_words);
    bad = 0;
    for (int i = 0; i < addrs.size(); i++) begin
      ea = AW'(NW - 1 - i);
      if (addrs[i] !== ea) bad++;
    end
    chk("addr_seq", bad, 0);
    chk("rd_single", rd_long, 0);
    chk("sin_idle", sin_bad, 0);
    chk("en_cycles", en_cnt, n_bits);
    chk("latch_cnt", latch_cnt, full ? 1 : 0);
    chk("done_cnt", done_cnt, full ? 1 : 0);
    chk("done_cyc", done_cyc, full ? RUN_CYC : -1);
  endtask

  task automatic run_b(input logic [7:0] word, input logic [8:0] exp9);
    logic [8:0] v;
    int dc, lc, nb;
    mem_b = word;
    v = '0; dc = -1; lc = 0; nb = 0;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (cfg_en_b) begin
        v = {v[7:0], sin_b};
        nb++;
      end
      if (cfg_latch_b) lc++;
      if (done_b && dc < 0) dc = cyc;
    end
    chk("b_bits", nb, 9);
    chk("b_stream", v, exp9);
    chk("b_latch", lc, 1);
    chk("b_done_cyc", dc, 13);
  endtask

  task automatic rand_image();
    for (int i = 0; i < 16; i++) mem_a[i] = $urandom;
  endtask

  initial begin
    int idle_bad;
    logic [7:0] wb;
    rand_image();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy_a, done_a, sin_a, cfg_en_a, cfg_latch_a, rom_a.rom_rd, rom_a.rom_addr}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default image with random filler words.
    rand_image();
    mem_a[14] = 32'h0000_0001;
    mem_a[13] = 32'h0000_0248;
    mem_a[0]  = 32'h0000_FF00;
    run_a(0, -1);
    verify_a(1'b1, -1);
    chk("head_zeros", got.size() >= 33 ? {got[0], got[31], got[32]} : 3'bxxx, 3'b001);

    rand_image();
    run_a(1, -1);
    verify_a(1'b1, -1);

    rand_image();
    run_a(2, -1);
    verify_a(1'b1, -1);

    // Abort during the SHIFT of word 7.
    rand_image();
    run_a(0, 7 * (WW + 3) + 15);
    verify_a(1'b0, 7 * (WW + 3) + 15);

    rand_image();
    run_a(0, -1);
    verify_a(1'b1, -1);

    // Asynchronous reset in the middle of a SHIFT.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (48) @(negedge clk);
    chk("pre_rst_en", cfg_en_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy_a, done_a, sin_a, cfg_en_a, cfg_latch_a, rom_a.rom_rd, rom_a.rom_addr}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({busy_a, done_a, sin_a, cfg_en_a, cfg_latch_a, rom_a.rom_rd} !== 6'b0) idle_bad++;
    end
    chk("rst_idle", idle_bad, 0);

    rand_image();
    run_a(0, -1);
    verify_a(1'b1, -1);

    run_b(8'hA5, 9'b0_1010_0101);
    wb = 8'($urandom);
    run_b(wb, {1'b0, wb});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
